// File: rtl/rc4_message_checker.sv
// rc4_message_checker: scans decrypted RAM, passes only if every byte is 'a'..'z' or space.
// Define RC4_CHECKER_EARLY_ABORT_EN to finish on the first illegal byte.
module rc4_message_checker #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    output logic [ADDR_W-1:0] Msg_Addr,
    input  logic [7:0]        Msg_Data,
    output logic              Busy,
    output logic              Decrypt_Valid,
    output logic              Checker_Finish
);
`ifdef RC4_CHECKER_EARLY_ABORT_EN
    localparam bit EarlyAbort = 1'b1;
`else
    localparam bit EarlyAbort = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, READ, CHECK, DONE} state_t;
    state_t state_q;
    logic   all_ok_q;
    logic   legal;
    logic   stop;
    assign legal = (Msg_Data == 8'h20) || (Msg_Data >= 8'h61 && Msg_Data <= 8'h7A);
    assign stop  = (Msg_Addr == ADDR_W'(MSG_LEN - 1)) || (EarlyAbort && !legal);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            Msg_Addr       <= '0;
            Busy           <= 1'b0;
            Decrypt_Valid  <= 1'b0;
            Checker_Finish <= 1'b0;
            all_ok_q       <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (Start) begin
                    state_q       <= READ;
                    Msg_Addr      <= '0;
                    all_ok_q      <= 1'b1;
                    Decrypt_Valid <= 1'b0;
                    Busy          <= 1'b1;
                end
                READ: state_q <= CHECK;
                CHECK: begin
                    all_ok_q <= all_ok_q & legal;
                    if (stop) begin
                        state_q        <= DONE;
                        Busy           <= 1'b0;
                        Checker_Finish <= 1'b1;
                        Decrypt_Valid  <= all_ok_q & legal;
                    end else begin
                        Msg_Addr <= Msg_Addr + ADDR_W'(1);
                        state_q  <= READ;
                    end
                end
                default: begin
                    Checker_Finish <= 1'b0;
                    state_q        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rc4_message_checker.sv
// tb_rc4_message_checker: directed and random scans against a message-level reference model.
module tb_rc4_message_checker;
    localparam int N = 32;
`ifdef RC4_CHECKER_EARLY_ABORT_EN
    localparam bit EA = 1'b1;
`else
    localparam bit EA = 1'b0;
`endif
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [4:0] addr;
    logic [7:0] data;
    logic       busy, dv, fin;
    logic [7:0] mem [N];
    int         total = 0, bad = 0;
    logic       hold = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) data <= mem[addr];

    rc4_message_checker #(.MSG_LEN(N), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .Start(start), .Msg_Addr(addr), .Msg_Data(data),
        .Busy(busy), .Decrypt_Valid(dv), .Checker_Finish(fin)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [7:0] c);
        return c == " " || (c >= "a" && c <= "z");
    endfunction

    task automatic fill_legal();
        for (int i = 0; i < N; i++) begin
            int r = $urandom_range(0, 26);
            mem[i] = (r == 0) ? 8'h20 : 8'(8'h60 + r);
        end
    endtask

    task automatic run_scan(input string tag, input bit repulse);
        int k = -1, efin, eaddr, nfin = 0, first = 0, bsy = 0, mid = 0, held = 0;
        bit ok;
        for (int i = 0; i < N; i++) if (k < 0 && !legal(mem[i])) k = i;
        ok    = (k < 0);
        efin  = (EA && !ok) ? 2 * (k + 1) + 1 : 2 * N + 1;
        eaddr = (EA && !ok) ? k : N - 1;
        chk({tag, " held_before"}, dv, hold);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= efin + 35; n++) begin
            if (busy !== (n < efin)) bsy++;
            if (fin === 1'b1) begin
                nfin++;
                if (first == 0) first = n;
            end
            if (n < efin && dv !== 1'b0) mid++;
            if (n >= efin && dv !== ok) held++;
            if (n == efin) chk({tag, " addr"}, addr, eaddr);
            start = repulse && (n == 10 || n == efin);
            @(posedge clk); #1;
        end
        start = 1'b0;
        hold  = ok;
        chk({tag, " finish_cycle"}, first, efin);
        chk({tag, " finish_pulses"}, nfin, 1);
        chk({tag, " busy_errs"}, bsy, 0);
        chk({tag, " valid_midscan"}, mid, 0);
        chk({tag, " valid_result"}, held, 0);
    endtask

    initial begin
        string s = "attack at dawn";
        int nf = 0;
        fill_legal();
        #1;
        chk("rst addr", addr, 0);
        chk("rst busy", busy, 0);
        chk("rst valid", dv, 0);
        chk("rst finish", fin, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < N; i++) mem[i] = (i < s.len()) ? s[i] : 8'h20;
        run_scan("dawn", 1'b0);

        fill_legal(); mem[0] = 8'h20; mem[1] = 8'h61; mem[2] = 8'h7A;
        run_scan("bound_ok", 1'b0);
        mem[1] = 8'h60; run_scan("bound_60", 1'b0);
        mem[1] = 8'h7B; run_scan("bound_7b", 1'b0);
        mem[1] = 8'h1F; run_scan("bound_1f", 1'b0);

        fill_legal(); mem[3] = 8'h41;
        run_scan("upper_a", 1'b0);

        fill_legal(); mem[31] = 8'h7B;
        run_scan("last_bad", 1'b0);
        mem[31] = 8'h20;
        run_scan("last_fixed", 1'b0);

        fill_legal(); mem[5] = 8'h00;
        run_scan("repulse", 1'b1);
        run_scan("after_repulse", 1'b0);

        for (int t = 0; t < 8; t++) begin
            fill_legal();
            if ($urandom_range(0, 1) == 1) begin
                logic [7:0] b;
                do b = 8'($urandom); while (legal(b));
                mem[$urandom_range(0, N - 1)] = b;
            end
            run_scan($sformatf("rand%0d", t), 1'b0);
        end

        fill_legal();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst addr", addr, 0);
        chk("midrst busy", busy, 0);
        chk("midrst valid", dv, 0);
        chk("midrst finish", fin, 0);
        repeat (5) begin
            @(posedge clk); #1;
            if (fin !== 1'b0) nf++;
        end
        chk("midrst no_finish", nf, 0);
        rst  = 1'b0;
        hold = 1'b0;
        run_scan("post_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
